uart_mem_dump: RTL and testbench
================================

Name: uart_mem_dump

Overview:
- Reads a block of 16-bit words from the program/data BRAM and sends them out over the UART transmitter, high byte first.
- It is the transmit counterpart of the UART loader, which receives byte pairs and writes them to BRAM from 0x200 upward. Optionally it appends the same 0xFFFF terminator the loader uses.
- It sits between the top-level control logic, the BRAM read port and the uart tx_data/tx_en inputs.

Parameters:
- ADDR_WIDTH, 10, byte-address width; same value as the shared `ADDR_WIDTH`.
- RD_LATENCY, 1, cycles from mem_rd_addr being sampled by the BRAM to mem_rd_data being valid (1..3).
- TRAILER, 1, when 1, send bytes FF FF after the last word.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first byte address; bit 0 is ignored and forced to 0
- word_count  in  ADDR_WIDTH  number of 16-bit words to send; latched at start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final byte is handed to the UART
- mem_rd_addr  out  ADDR_WIDTH  BRAM byte read address; always even
- mem_rd_data  in  16  BRAM read data
- tx_data  out  8  byte to transmit
- tx_en  out  1  one-cycle strobe; the UART accepts tx_data on this cycle
- tx_ready  in  1  UART idle and able to accept a byte

Behaviour:
- All state is updated on posedge sys_clk. rst_n=0 at any edge, including mid-transfer, forces:
  - state IDLE
  - busy=0, done=0, tx_en=0, tx_data=0, mem_rd_addr=0
  - the remaining count is cleared; any byte already handed to the UART is not recalled.
- States: IDLE, READ, SEND_HI, SEND_LO, SEND_T0, SEND_T1, GAP, DONE.
- IDLE:
  - On start=1: latch addr={start_addr[ADDR_WIDTH-1:1],1'b0} and cnt=word_count.
  - If cnt!=0 go to READ; else go to SEND_T0 if TRAILER=1, else DONE.
- READ:
  - mem_rd_addr is driven with addr for RD_LATENCY+1 cycles.
  - On the last of those cycles, mem_rd_data is latched into the word register; next state SEND_HI.
- SEND_HI:
  - Wait while tx_ready=0.
  - When tx_ready=1: tx_en=1 for one cycle with tx_data=word[15:8], then GAP, returning to SEND_LO.
- SEND_LO: same as SEND_HI with word[7:0]. On completion:
  - cnt decrements and addr increases by 2, wrapping modulo 2^ADDR_WIDTH (0x3FE -> 0x000).
  - Then GAP. Next state is READ if cnt!=0; otherwise SEND_T0 if TRAILER=1, else DONE.
- SEND_T0 / SEND_T1: send 0xFF each, same handshake and GAP rules; SEND_T1 leads to DONE.
- GAP: exactly one cycle with tx_en=0, so tx_en is never high on two consecutive cycles. tx_ready is ignored in this cycle.
- DONE: done=1 for one cycle, busy=0 on the same cycle, then IDLE.
- busy is high throughout READ through GAP and low in IDLE and DONE.
- start while busy or in DONE: ignored.
- Latency with RD_LATENCY=1 and tx_ready held high, start at cycle 0:
  - mem_rd_addr valid in cycles 1-2
  - first tx_en (high byte) in cycle 3
  - low-byte tx_en in cycle 5
  - next word's tx_en in cycle 9
- tx_data holds its value until the next tx_en.
- word_count=0 with TRAILER=0: done pulses in cycle 1 and no tx_en occurs.

Decomposition:
- The shared package holds:
  - the state enum for the state machine
  - the TRAILER_BYTE=8'hFF constant, shared with the loader's completion check
  - the LOAD_BASE=`ADDR_WIDTH'h200 constant, shared with the loader's start address
- One natural sub-module, tx_byte_handshake: it takes a byte plus a valid flag, waits for tx_ready, issues the tx_en pulse and the GAP cycle, and returns an accepted pulse. The state machine and address/count logic stay in uart_mem_dump.

Test Plan:
- Basic dump: BRAM[0x200]=0x1234, [0x202]=0xABCD; start_addr=0x200, word_count=2, TRAILER=1, tx_ready=1 -> tx bytes 12 34 AB CD FF FF. Read addresses 0x200 then 0x202. done pulses once, the cycle after the last tx_en.
- Backpressure: same setup; tx_ready is dropped for 20 cycles after each tx_en -> same byte order; each tx_en occurs only while tx_ready=1; no two consecutive tx_en cycles.
- Odd start/wrap: start_addr=0x3FF, word_count=2, BRAM[0x3FE]=0x00AA, [0x000]=0x5500 -> read addresses 0x3FE then 0x000; bytes 00 AA 55 00 FF FF.
- Zero count: word_count=0 with TRAILER=0 -> done at cycle 1, tx_en never asserted. With TRAILER=1 -> only FF FF is sent.
- Start while busy: a second start pulse with start_addr=0x000 mid-transfer -> ignored; the original sequence completes unchanged.
- Reset mid-operation: rst_n=0 for one cycle after the first byte is sent -> on the next edge busy=0, tx_en=0, mem_rd_addr=0. A later start with word_count=1 sends exactly 2 bytes plus the trailer.

Source files
------------

// File: rtl/uart_mem_dump_pkg.sv
// Shared definitions for the BRAM-to-UART dump engine and its companion loader.
//   state_t      : dump state machine encoding
//   TRAILER_BYTE : end-of-image marker byte (loader looks for FF FF)
//   LOAD_BASE    : byte address where the loader starts writing images
package uart_mem_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND_HI,
    SEND_LO,
    SEND_T0,
    SEND_T1,
    GAP,
    DONE
  } state_t;

  localparam logic [7:0] TRAILER_BYTE = 8'hFF;

  localparam int LOADER_ADDR_WIDTH = 10;
  localparam logic [LOADER_ADDR_WIDTH-1:0] LOAD_BASE = 10'h200;

endpackage

// File: rtl/uart_mem_dump_tx_byte_handshake.sv
// Single-byte handshake toward the UART transmitter.
//   sys_clk, rst_n : clock, synchronous active-low reset
//   data, valid    : byte offered by the state machine
//   tx_ready       : UART can take a byte this cycle
//   tx_data, tx_en : UART byte and one-cycle strobe
//   accepted       : the offered byte was handed over this cycle
// tx_en is combinational so the strobe lands in the same cycle the byte is
// offered; tx_data keeps showing the last handed-over byte between strobes.
module uart_mem_dump_tx_byte_handshake (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       accepted
);

  logic       gap;
  logic [7:0] held;

  // The cycle right after a strobe is a forced gap, whatever tx_ready says.
  assign tx_en    = valid & tx_ready & ~gap;
  assign accepted = tx_en;
  assign tx_data  = tx_en ? data : held;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      gap  <= 1'b0;
      held <= 8'h00;
    end else begin
      gap <= tx_en;
      if (tx_en) begin
        held <= data;
      end
    end
  end

endmodule

// File: rtl/uart_mem_dump.sv
// Dumps a block of 16-bit BRAM words over the UART, high byte first, with an
// optional FF FF trailer matching the loader's end marker.
//   sys_clk, rst_n         : clock, synchronous active-low reset
//   start                  : one-cycle request, honoured only in IDLE
//   start_addr, word_count : first byte address (forced even), words to send
//   busy, done             : transfer in progress / one-cycle completion pulse
//   mem_rd_addr            : BRAM byte read address (always even)
//   mem_rd_data            : BRAM read data, RD_LATENCY cycles after the address
//   tx_data, tx_en         : byte and strobe toward the UART
//   tx_ready               : UART able to accept a byte
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1,
  parameter int TRAILER    = 1
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [15:0]           mem_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_en,
  input  logic                  tx_ready
);

  localparam logic [1:0] RD_LAST = 2'(RD_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

  state_t                state, state_d;
  state_t                ret, ret_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic [ADDR_WIDTH-1:0] cnt, cnt_d;
  logic [15:0]           word, word_d;
  logic [1:0]            rd_cnt, rd_cnt_d;
  logic [7:0]            byte_val;
  logic                  byte_vld;
  logic                  accepted;

  uart_mem_dump_tx_byte_handshake u_hs (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .data     (byte_val),
    .valid    (byte_vld),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .accepted (accepted)
  );

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ret    <= IDLE;
      addr   <= '0;
      cnt    <= '0;
      word   <= 16'h0000;
      rd_cnt <= 2'd0;
    end else begin
      state  <= state_d;
      ret    <= ret_d;
      addr   <= addr_d;
      cnt    <= cnt_d;
      word   <= word_d;
      rd_cnt <= rd_cnt_d;
    end
  end

  always_comb begin
    state_d  = state;
    ret_d    = ret;
    addr_d   = addr;
    cnt_d    = cnt;
    word_d   = word;
    rd_cnt_d = 2'd0;
    byte_val = 8'h00;
    byte_vld = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          addr_d = start_addr & ~ONE;
          cnt_d  = word_count;
          if (word_count != '0) begin
            state_d = READ;
          end else if (TRAILER != 0) begin
            state_d = SEND_T0;
          end else begin
            state_d = DONE;
          end
        end
      end

      // Address is held for RD_LATENCY+1 cycles; data is taken on the last.
      READ: begin
        if (rd_cnt == RD_LAST) begin
          word_d  = mem_rd_data;
          state_d = SEND_HI;
        end else begin
          rd_cnt_d = rd_cnt + 2'd1;
        end
      end

      SEND_HI: begin
        byte_val = word[15:8];
        byte_vld = 1'b1;
        if (accepted) begin
          ret_d   = SEND_LO;
          state_d = GAP;
        end
      end

      SEND_LO: begin
        byte_val = word[7:0];
        byte_vld = 1'b1;
        if (accepted) begin
          cnt_d  = cnt - ONE;
          addr_d = addr + TWO;
          if (cnt != ONE) begin
            ret_d   = READ;
            state_d = GAP;
          end else if (TRAILER != 0) begin
            ret_d   = SEND_T0;
            state_d = GAP;
          end else begin
            // DONE has tx_en low, so it doubles as the trailing gap.
            state_d = DONE;
          end
        end
      end

      SEND_T0: begin
        byte_val = TRAILER_BYTE;
        byte_vld = 1'b1;
        if (accepted) begin
          ret_d   = SEND_T1;
          state_d = GAP;
        end
      end

      SEND_T1: begin
        byte_val = TRAILER_BYTE;
        byte_vld = 1'b1;
        if (accepted) begin
          state_d = DONE;
        end
      end

      GAP: begin
        state_d = ret;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign mem_rd_addr = addr;

endmodule

// File: tb/tb_uart_mem_dump.sv
module tb_uart_mem_dump;

  logic       clk;
  logic       rst_n;
  logic       start, start2;
  logic [9:0] start_addr, word_count;
  logic       busy, done, tx_en, tx_ready;
  logic [9:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic [7:0] tx_data;
  logic       busy2, done2, tx_en2;
  logic [9:0] addr2;
  logic [7:0] tx_data2;

  logic [15:0] mem [0:511];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int base = 0;
  bit log_on = 0;
  bit bp = 0;
  bit prev_en = 0;
  int n_rdy_viol = 0;
  int n_consec = 0;
  int n_odd = 0;

  logic [7:0] byte_q[$];
  int         en_q[$];
  int         done_q[$];
  logic [9:0] addr_q[$];
  bit         busy_q[$];

  uart_mem_dump #(.ADDR_WIDTH(10), .RD_LATENCY(1), .TRAILER(1)) dut (
    .sys_clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .tx_data(tx_data), .tx_en(tx_en), .tx_ready(tx_ready)
  );

  uart_mem_dump #(.ADDR_WIDTH(10), .RD_LATENCY(1), .TRAILER(0)) dut_nt (
    .sys_clk(clk), .rst_n(rst_n), .start(start2), .start_addr(start_addr),
    .word_count(word_count), .busy(busy2), .done(done2), .mem_rd_addr(addr2),
    .mem_rd_data(16'h0000), .tx_data(tx_data2), .tx_en(tx_en2), .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model, one cycle read latency
  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr[9:1]];

  always @(negedge clk) begin
    if (log_on) begin
      addr_q.push_back(mem_rd_addr);
      busy_q.push_back(busy);
      if (mem_rd_addr[0]) n_odd <= n_odd + 1;
      if (tx_en) begin
        byte_q.push_back(tx_data);
        en_q.push_back(cyc - base);
        if (!tx_ready) n_rdy_viol <= n_rdy_viol + 1;
        if (prev_en) n_consec <= n_consec + 1;
      end
      if (done) done_q.push_back(cyc - base);
    end
    prev_en <= tx_en;
  end

  // tx_ready driver: held high, or dropped 20 cycles after each strobe
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp && tx_en) begin
        @(posedge clk); #1 tx_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_bytes(input string tag, input logic [47:0] v, input int n);
    chk({tag, "_nbytes"}, 32'(byte_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), (i < byte_q.size()) ? 32'(byte_q[i]) : 32'hDEAD,
          32'(v[8*(n-1-i) +: 8]));
    end
  endtask

  task automatic q_int(input int q[$], input int idx, output logic [31:0] val);
    val = (idx < q.size()) ? 32'(q[idx]) : 32'hFFFF_FFFF;
  endtask

  task automatic start_log();
    byte_q.delete(); en_q.delete(); done_q.delete(); addr_q.delete(); busy_q.delete();
    base   = cyc;
    log_on = 1'b1;
  endtask

  task automatic run(input logic [9:0] sa, input logic [9:0] wc, input bit use_bp,
                     input bit mid, input int max_cyc);
    bit seen = 0;
    @(posedge clk); #1;
    start_addr = sa; word_count = wc; bp = use_bp; start = 1'b1;
    start_log();
    for (int i = 1; i <= max_cyc && !seen; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mid && (i == 5 || i == 10)) begin
        start = 1'b1; start_addr = 10'h000; word_count = 10'd1;
      end
      if (done_q.size() > 0) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    repeat (3) @(posedge clk);
    #1 bp = 1'b0;
    chk("done_once", 32'(done_q.size()), 32'd1);
    chk("rdy_viol", 32'(n_rdy_viol), 32'd0);
    chk("consec_en", 32'(n_consec), 32'd0);
  endtask

  logic [31:0] v;

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    start_addr = 10'h000; word_count = 10'd0;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[9'h100] = 16'h1234;
    mem[9'h101] = 16'hABCD;
    mem[9'h1FF] = 16'h00AA;
    mem[9'h000] = 16'h5500;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_nt_busy", 32'(busy2), 32'd0);
    chk("rst_nt_tx_data", 32'(tx_data2), 32'd0);
    chk("rst_nt_addr", 32'(addr2), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // basic dump with timing
    run(10'h200, 10'd2, 0, 0, 100);
    chk_bytes("basic", 48'h1234ABCDFFFF, 6);
    q_int(en_q, 0, v); chk("basic_en0_cyc", v, 32'd3);
    q_int(en_q, 1, v); chk("basic_en1_cyc", v, 32'd5);
    q_int(en_q, 2, v); chk("basic_en2_cyc", v, 32'd9);
    q_int(en_q, 5, v); chk("basic_en5_cyc", v, 32'd15);
    q_int(done_q, 0, v); chk("basic_done_cyc", v, 32'd16);
    chk("basic_addr_c1", 32'(addr_q[1]), 32'h200);
    chk("basic_addr_c2", 32'(addr_q[2]), 32'h200);
    chk("basic_addr_c7", 32'(addr_q[7]), 32'h202);
    chk("basic_addr_c8", 32'(addr_q[8]), 32'h202);
    chk("basic_busy_c0", 32'(busy_q[0]), 32'd0);
    chk("basic_busy_c1", 32'(busy_q[1]), 32'd1);
    chk("basic_busy_c16", 32'(busy_q[16]), 32'd0);

    // backpressure
    run(10'h200, 10'd2, 1, 0, 400);
    chk_bytes("bp", 48'h1234ABCDFFFF, 6);
    repeat (25) @(posedge clk);

    // odd start address and wrap past the top of memory
    run(10'h3FF, 10'd2, 0, 0, 100);
    chk_bytes("wrap", 48'h00AA5500FFFF, 6);
    chk("wrap_addr_c1", 32'(addr_q[1]), 32'h3FE);
    chk("wrap_addr_c7", 32'(addr_q[7]), 32'h000);

    // zero count with trailer
    run(10'h200, 10'd0, 0, 0, 50);
    chk_bytes("zero_tr", 48'h00000000FFFF, 2);
    q_int(en_q, 0, v); chk("zero_tr_en0_cyc", v, 32'd1);
    q_int(done_q, 0, v); chk("zero_tr_done_cyc", v, 32'd4);

    // zero count without trailer
    begin
      int done_at = -1;
      int n_done = 0;
      int n_en = 0;
      @(posedge clk); #1;
      word_count = 10'd0; start_addr = 10'h200; start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      for (int k = 1; k < 8; k++) begin
        @(negedge clk);
        if (done2) begin n_done++; done_at = k; end
        if (tx_en2) n_en++;
        @(posedge clk); #1;
      end
      chk("zero_nt_done_cyc", 32'(done_at), 32'd1);
      chk("zero_nt_done_cnt", 32'(n_done), 32'd1);
      chk("zero_nt_tx_en", 32'(n_en), 32'd0);
    end

    // start while busy is ignored
    run(10'h200, 10'd2, 0, 1, 100);
    chk_bytes("midstart", 48'h1234ABCDFFFF, 6);
    q_int(done_q, 0, v); chk("midstart_done_cyc", v, 32'd16);

    // reset mid-operation
    @(posedge clk); #1;
    start_addr = 10'h200; word_count = 10'd2; start = 1'b1;
    start_log();
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 4) rst_n = 1'b0;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx_en", 32'(tx_en), 32'd0);
    chk("midrst_addr", 32'(mem_rd_addr), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk_bytes("midrst_pre", 48'h000000000012, 1);
    repeat (5) @(posedge clk);
    chk("midrst_idle_busy", 32'(busy), 32'd0);
    run(10'h200, 10'd1, 0, 0, 100);
    chk_bytes("postrst", 48'h00001234FFFF, 4);

    chk("odd_addr", 32'(n_odd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
